// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared types, LED constants and width helpers for the timer core
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } tc_state_t;

    localparam logic [7:0] LED_IDLE  = 8'h00;
    localparam logic [7:0] LED_PAUSE = 8'h81;
    localparam logic [7:0] LED_DONE  = 8'hFF;

    // Bits needed to hold 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

    // Bits needed to hold 0..div-1.
    function automatic int psc_width(input int div);
        return (div < 3) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tc_prescaler.sv
// rtl/tc_prescaler.sv - divide-by-DIV prescaler with hold and clear
// ports: sysclk/i_rst clock and async reset; i_en advance one step; i_clr zero (wins over i_en);
//        o_wrap high in the cycle whose edge takes the count from DIV-1 back to 0
module tc_prescaler
    import tc_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic sysclk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_wrap
);

    localparam int              PSC_W = psc_width(DIV);
    localparam logic [PSC_W-1:0] LAST = PSC_W'(DIV - 1);

    logic [PSC_W-1:0] cnt;

    // With i_en low the count simply holds, so a held DIV-1 resumes straight into a wrap.
    assign o_wrap = i_en && !i_clr && (cnt == LAST);

    always_ff @(posedge sysclk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PSC_W'(1);
        end
    end

endmodule

// File: rtl/tc_timer_core.sv
// rtl/tc_timer_core.sv - stopwatch / countdown timer with run, pause, clear and load
// ports: sysclk/i_rst clock and async reset; i_start/i_stop/i_clear command pulses;
//        i_mode 0 up 1 down; i_load/i_load_val preset; o_timeData count; o_tcLED status;
//        o_running in RUN; o_tick count updated; o_done entry to DONE
module tc_timer_core
    import tc_pkg::*;
#(
    parameter int  CLK_HZ    = 100_000_000,
    parameter int  TICK_HZ   = 10,
    parameter int  MAX_COUNT = 9999,
    parameter int  WRAP_UP   = 1,
    localparam int CNT_W     = cnt_width(MAX_COUNT)
) (
    input  logic             sysclk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_clear,
    input  logic             i_mode,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_timeData,
    output logic [7:0]       o_tcLED,
    output logic             o_running,
    output logic             o_tick,
    output logic             o_done
);

    localparam int               DIV   = CLK_HZ / TICK_HZ;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    tc_state_t        state;
    tc_state_t        nxt_state;
    logic             mode_q;
    logic             nxt_mode;
    logic [CNT_W-1:0] nxt_count;
    logic             nxt_tick;
    logic             nxt_done;
    logic [7:0]       nxt_led;
    logic [2:0]       led_sel;
    logic             psc_en;
    logic             psc_clr;
    logic             psc_wrap;

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
        return (v > MAX_C) ? MAX_C : v;
    endfunction

    // The resume edge itself counts while the stop edge does not, so a pause never
    // gains or loses a prescaler step; a stop on the wrap edge leaves it parked at DIV-1.
    assign psc_en  = !i_clear && !i_stop &&
                     ((state == RUN) || ((state == PAUSE) && i_start));
    assign psc_clr = i_clear || (state == IDLE) || (state == DONE);

    tc_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .sysclk (sysclk),
        .i_rst  (i_rst),
        .i_en   (psc_en),
        .i_clr  (psc_clr),
        .o_wrap (psc_wrap)
    );

    always_comb begin
        nxt_state = state;
        nxt_mode  = mode_q;
        nxt_count = o_timeData;
        nxt_tick  = 1'b0;
        nxt_done  = 1'b0;
        nxt_led   = LED_IDLE;
        led_sel   = 3'd0;

        case (state)
            IDLE: begin
                if (i_clear) begin
                    nxt_count = '0;
                end else if (!i_stop) begin
                    if (i_start) begin
                        // A countdown from zero has nothing to do.
                        if (!(i_mode && (o_timeData == '0))) begin
                            nxt_state = RUN;
                            nxt_mode  = i_mode;
                        end
                    end else if (i_load) begin
                        nxt_count = clamp(i_load_val);
                    end
                end
            end
            RUN: begin
                if (i_clear) begin
                    nxt_state = IDLE;
                    nxt_count = '0;
                end else if (i_stop) begin
                    nxt_state = PAUSE;
                end
            end
            PAUSE: begin
                if (i_clear) begin
                    nxt_state = IDLE;
                    nxt_count = '0;
                end else if (!i_stop) begin
                    if (i_start) begin
                        nxt_state = RUN;
                    end else if (i_load) begin
                        nxt_count = clamp(i_load_val);
                    end
                end
            end
            DONE: begin
                if (i_clear) begin
                    nxt_state = IDLE;
                    nxt_count = '0;
                end
            end
            default: nxt_state = IDLE;
        endcase

        // psc_wrap implies no clear/stop this cycle and a RUN next, so it may override.
        if (psc_wrap) begin
            if (!mode_q) begin
                if (o_timeData == MAX_C) begin
                    if (WRAP_UP != 0) begin
                        nxt_count = '0;
                        nxt_tick  = 1'b1;
                    end else begin
                        nxt_state = DONE;
                        nxt_done  = 1'b1;
                    end
                end else begin
                    nxt_count = o_timeData + CNT_W'(1);
                    nxt_tick  = 1'b1;
                end
            end else begin
                if (o_timeData == '0) begin
                    // Only reachable after a zero load in PAUSE; finish without an update.
                    nxt_state = DONE;
                    nxt_done  = 1'b1;
                end else begin
                    nxt_count = o_timeData - CNT_W'(1);
                    nxt_tick  = 1'b1;
                    if (o_timeData == CNT_W'(1)) begin
                        nxt_state = DONE;
                        nxt_done  = 1'b1;
                    end
                end
            end
        end

        led_sel = 3'(nxt_count);
        case (nxt_state)
            RUN:     nxt_led = 8'h01 << led_sel;
            PAUSE:   nxt_led = LED_PAUSE;
            DONE:    nxt_led = LED_DONE;
            default: nxt_led = LED_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            o_timeData <= '0;
            o_tcLED    <= 8'h00;
            o_running  <= 1'b0;
            o_tick     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= nxt_state;
            mode_q     <= nxt_mode;
            o_timeData <= nxt_count;
            o_tcLED    <= nxt_led;
            o_running  <= (nxt_state == RUN);
            o_tick     <= nxt_tick;
            o_done     <= nxt_done;
        end
    end

endmodule

// File: tb/tb_tc_timer_core.sv
// tb/tb_tc_timer_core.sv - directed bench for tc_timer_core (DIV=10, MAX_COUNT=20)
module tb_tc_timer_core;

    typedef struct {
        logic       start;
        logic       stop;
        logic       clear;
        logic       mode;
        logic       load;
        logic [4:0] lval;
        int         e_cnt;
        int         e_led;
        int         e_run;
        int         e_tick;
        int         e_done;
    } vec_t;

    logic       sysclk;
    logic       i_rst;
    logic       i_start;
    logic       i_stop;
    logic       i_clear;
    logic       i_mode;
    logic       i_load;
    logic [4:0] i_load_val;

    logic [4:0] w_cnt;
    logic [7:0] w_led;
    logic       w_run;
    logic       w_tick;
    logic       w_done;
    logic [4:0] s_cnt;
    logic [7:0] s_led;
    logic       s_run;
    logic       s_tick;
    logic       s_done;

    int n_checks;
    int n_fail;

    vec_t vecs[13];

    tc_timer_core #(
        .CLK_HZ    (100),
        .TICK_HZ   (10),
        .MAX_COUNT (20),
        .WRAP_UP   (1)
    ) u_wrap (
        .sysclk     (sysclk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_clear    (i_clear),
        .i_mode     (i_mode),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .o_timeData (w_cnt),
        .o_tcLED    (w_led),
        .o_running  (w_run),
        .o_tick     (w_tick),
        .o_done     (w_done)
    );

    tc_timer_core #(
        .CLK_HZ    (100),
        .TICK_HZ   (10),
        .MAX_COUNT (20),
        .WRAP_UP   (0)
    ) u_sat (
        .sysclk     (sysclk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_clear    (i_clear),
        .i_mode     (i_mode),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .o_timeData (s_cnt),
        .o_tcLED    (s_led),
        .o_running  (s_run),
        .o_tick     (s_tick),
        .o_done     (s_done)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    function automatic vec_t mk(input logic s, input logic p, input logic c, input logic m,
                                input logic l, input logic [4:0] lv, input int ec,
                                input int el, input int er, input int et, input int ed);
        vec_t v;
        v.start = s; v.stop = p; v.clear = c; v.mode = m; v.load = l; v.lval = lv;
        v.e_cnt = ec; v.e_led = el; v.e_run = er; v.e_tick = et; v.e_done = ed;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ec, input int el, input int er,
                           input int et, input int ed);
        check({tag, ".cnt"},  int'(w_cnt),  ec);
        check({tag, ".led"},  int'(w_led),  el);
        check({tag, ".run"},  int'(w_run),  er);
        check({tag, ".tick"}, int'(w_tick), et);
        check({tag, ".done"}, int'(w_done), ed);
    endtask

    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle();
        i_start = 1'b0; i_stop = 1'b0; i_clear = 1'b0;
        i_mode = 1'b0; i_load = 1'b0; i_load_val = 5'd0;
    endtask

    task automatic drive(input logic s, input logic p, input logic c, input logic m,
                         input logic l, input logic [4:0] lv);
        i_start = s; i_stop = p; i_clear = c; i_mode = m; i_load = l; i_load_val = lv;
    endtask

    // One-cycle command pulse: drive, take one edge, release.
    task automatic pulse(input logic s, input logic p, input logic c, input logic m,
                         input logic l, input logic [4:0] lv);
        drive(s, p, c, m, l, lv);
        cyc();
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        i_rst = 1'b1;

        // start, stop, clear, mode, load, lval -> cnt, led, run, tick, done
        vecs[0]  = mk(0, 0, 0, 0, 1, 5'd31, 20, 8'h00, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 1, 5'd5,   5, 8'h00, 0, 0, 0);
        vecs[2]  = mk(0, 0, 1, 0, 1, 5'd7,   0, 8'h00, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 1, 5'd3,   3, 8'h00, 0, 0, 0);
        vecs[4]  = mk(1, 0, 1, 1, 0, 5'd0,   0, 8'h00, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 1, 0, 5'd0,   0, 8'h00, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 1, 5'd2,   2, 8'h00, 0, 0, 0);
        vecs[7]  = mk(1, 1, 0, 1, 0, 5'd0,   2, 8'h00, 0, 0, 0);
        vecs[8]  = mk(1, 0, 0, 1, 1, 5'd9,   2, 8'h04, 1, 0, 0);
        vecs[9]  = mk(0, 1, 0, 0, 0, 5'd0,   2, 8'h81, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 5'd31, 20, 8'h81, 0, 0, 0);
        vecs[11] = mk(1, 0, 0, 0, 0, 5'd0,  20, 8'h10, 1, 0, 0);
        vecs[12] = mk(0, 0, 1, 0, 0, 5'd0,   0, 8'h00, 0, 0, 0);

        repeat (2) @(posedge sysclk);
        #1;
        chk_all("reset", 0, 8'h00, 0, 0, 0);
        check("reset.sat_cnt", int'(s_cnt), 0);
        check("reset.sat_led", int'(s_led), 0);
        i_rst = 1'b0;
        cyc();

        // Single-cycle command table: priorities, clamp and ignored starts.
        for (int k = 0; k < 13; k++) begin
            pulse(vecs[k].start, vecs[k].stop, vecs[k].clear, vecs[k].mode,
                  vecs[k].load, vecs[k].lval);
            chk_all($sformatf("vec%0d", k), vecs[k].e_cnt, vecs[k].e_led,
                    vecs[k].e_run, vecs[k].e_tick, vecs[k].e_done);
        end

        // Up count: ticks at 10, 20, 30 cycles after the start edge.
        pulse(1, 0, 0, 0, 0, 5'd0);
        chk_all("up.start", 0, 8'h01, 1, 0, 0);
        for (int n = 1; n <= 30; n++) begin
            cyc();
            check($sformatf("up.tick@%0d", n), int'(w_tick), (n % 10 == 0) ? 1 : 0);
            check($sformatf("up.cnt@%0d", n), int'(w_cnt), n / 10);
        end
        check("up.led3", int'(w_led), 8'h08);

        // Pause 5 cycles after the tick, hold 50, resume: tick 5 cycles later.
        repeat (4) cyc();
        pulse(0, 1, 0, 0, 0, 5'd0);
        chk_all("pause", 3, 8'h81, 0, 0, 0);
        for (int n = 0; n < 50; n++) begin
            cyc();
            check("pause.hold_tick", int'(w_tick), 0);
            check("pause.hold_led", int'(w_led), 8'h81);
        end
        pulse(1, 0, 0, 0, 0, 5'd0);
        chk_all("resume", 3, 8'h08, 1, 0, 0);
        for (int n = 1; n <= 5; n++) begin
            cyc();
            check($sformatf("resume.tick@%0d", n), int'(w_tick), (n == 5) ? 1 : 0);
            check($sformatf("resume.cnt@%0d", n), int'(w_cnt), (n == 5) ? 4 : 3);
        end

        // Stop on the wrap edge: no tick; the parked wrap lands on the resume edge.
        for (int n = 0; n < 9; n++) begin
            cyc();
            check("stopwrap.pre_tick", int'(w_tick), 0);
        end
        pulse(0, 1, 0, 0, 0, 5'd0);
        chk_all("stopwrap", 4, 8'h81, 0, 0, 0);
        pulse(1, 0, 0, 0, 0, 5'd0);
        chk_all("stopwrap.resume", 5, 8'h20, 1, 1, 0);
        pulse(0, 0, 1, 0, 0, 5'd0);
        chk_all("stopwrap.clear", 0, 8'h00, 0, 0, 0);

        // Countdown from a load of 3.
        pulse(0, 0, 0, 0, 1, 5'd3);
        check("down.load", int'(w_cnt), 3);
        pulse(1, 0, 0, 1, 0, 5'd0);
        chk_all("down.start", 3, 8'h08, 1, 0, 0);
        for (int n = 1; n <= 30; n++) begin
            cyc();
            check($sformatf("down.tick@%0d", n), int'(w_tick), (n % 10 == 0) ? 1 : 0);
            check($sformatf("down.cnt@%0d", n), int'(w_cnt), 3 - n / 10);
            check($sformatf("down.done@%0d", n), int'(w_done), (n == 30) ? 1 : 0);
        end
        check("down.led_done", int'(w_led), 8'hFF);
        check("down.run_done", int'(w_run), 0);
        cyc();
        check("down.done_once", int'(w_done), 0);
        pulse(1, 0, 0, 1, 0, 5'd0);
        chk_all("down.ign_start1", 0, 8'hFF, 0, 0, 0);
        pulse(1, 0, 0, 0, 0, 5'd0);
        chk_all("down.ign_start0", 0, 8'hFF, 0, 0, 0);
        pulse(0, 0, 1, 0, 0, 5'd0);
        chk_all("down.clear", 0, 8'h00, 0, 0, 0);

        // Upper limit: wrap vs saturate.
        pulse(0, 0, 0, 0, 1, 5'd18);
        pulse(1, 0, 0, 0, 0, 5'd0);
        for (int n = 1; n <= 31; n++) begin
            cyc();
            if (n == 10) check("lim.cnt19", int'(w_cnt), 19);
            if (n == 20) begin
                check("lim.w_cnt20", int'(w_cnt), 20);
                check("lim.s_cnt20", int'(s_cnt), 20);
                check("lim.led20", int'(w_led), 8'h10);
                check("lim.s_done20", int'(s_done), 0);
            end
            if (n == 30) begin
                chk_all("lim.wrap", 0, 8'h01, 1, 1, 0);
                check("lim.sat_cnt", int'(s_cnt), 20);
                check("lim.sat_done", int'(s_done), 1);
                check("lim.sat_tick", int'(s_tick), 0);
                check("lim.sat_run", int'(s_run), 0);
                check("lim.sat_led", int'(s_led), 8'hFF);
            end
            if (n == 31) begin
                check("lim.sat_done_once", int'(s_done), 0);
                check("lim.sat_hold", int'(s_cnt), 20);
            end
        end
        pulse(0, 0, 1, 0, 0, 5'd0);
        check("lim.sat_clear", int'(s_cnt), 0);

        // Asynchronous reset mid-period at count 7.
        pulse(0, 0, 0, 0, 1, 5'd7);
        pulse(1, 0, 0, 0, 0, 5'd0);
        chk_all("arst.run7", 7, 8'h80, 1, 0, 0);
        repeat (3) cyc();
        i_rst = 1'b1;
        #2;
        chk_all("arst.async", 0, 8'h00, 0, 0, 0);
        check("arst.sat_cnt", int'(s_cnt), 0);
        #2;
        i_rst = 1'b0;
        cyc();
        chk_all("arst.idle", 0, 8'h00, 0, 0, 0);
        pulse(1, 0, 0, 0, 0, 5'd0);
        for (int n = 1; n <= 10; n++) begin
            cyc();
            check($sformatf("arst.tick@%0d", n), int'(w_tick), (n == 10) ? 1 : 0);
        end
        check("arst.cnt1", int'(w_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
